// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM destination shadows to drive forwarding
// selects, load-use stalls, taken-branch flushes and memory-busy freezes.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_reg_write,
  input  logic        id_is_load,
  input  logic        ex_taken,
  input  logic        mem_busy,
  output logic [1:0]  fwd_src1,
  output logic [1:0]  fwd_src2,
  output logic        stall_pc,
  output logic        stall_id,
  output logic        flush_ex,
  output logic        flush_id,
  output logic        freeze,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] freeze_cnt
);

  localparam logic [1:0] RS_DATA = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } shadow_t;

  typedef enum logic [1:0] {
    MODE_ADV    = 2'd0,
    MODE_LU     = 2'd1,
    MODE_TAKEN  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  localparam shadow_t SHADOW_NONE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, is_load: 1'b0};

  shadow_t ex_r, mem_r, id_shadow_s;
  mode_t   mode_s;
  logic    lu_s;
  logic [1:0] fwd1_s, fwd2_s;

  // A stage only creates a hazard when it will really write a non-zero register.
  function automatic logic is_src(input shadow_t s);
    return s.valid & s.reg_write & (s.rd != 5'd0);
  endfunction

  function automatic logic hits(input shadow_t s, input logic used, input logic [4:0] addr);
    return used & is_src(s) & (s.rd == addr);
  endfunction

  // Youngest producer wins: EX is checked ahead of MEM.
  function automatic logic [1:0] fwd_sel(input logic valid, input logic used,
                                         input logic [4:0] addr,
                                         input shadow_t ex_s, input shadow_t mem_s);
    if (!valid || !used) begin
      return RS_DATA;
    end else if (hits(ex_s, 1'b1, addr)) begin
      return FWD_MEM;
    end else if (hits(mem_s, 1'b1, addr)) begin
      return FWD_WB;
    end else begin
      return RS_DATA;
    end
  endfunction

  assign id_shadow_s = '{valid: id_valid, rd: id_rd_addr,
                         reg_write: id_reg_write, is_load: id_is_load};

  // Hazard detection, priority resolution and next forwarding selects.
  always_comb begin
    lu_s   = id_valid & ex_r.is_load &
             (hits(ex_r, id_rs1_used, id_rs1_addr) | hits(ex_r, id_rs2_used, id_rs2_addr));
    fwd1_s = fwd_sel(id_valid, id_rs1_used, id_rs1_addr, ex_r, mem_r);
    fwd2_s = fwd_sel(id_valid, id_rs2_used, id_rs2_addr, ex_r, mem_r);
    if (mem_busy) begin
      mode_s = MODE_FREEZE;
    end else if (ex_taken) begin
      mode_s = MODE_TAKEN;
    end else if (lu_s) begin
      mode_s = MODE_LU;
    end else begin
      mode_s = MODE_ADV;
    end
  end

  // Same-cycle pipeline control; reset forces a bubble everywhere.
  always_comb begin
    stall_pc = 1'b0;
    stall_id = 1'b0;
    flush_ex = 1'b0;
    flush_id = 1'b0;
    freeze   = 1'b0;
    if (rst) begin
      flush_ex = 1'b1;
      flush_id = 1'b1;
    end else begin
      case (mode_s)
        MODE_FREEZE: begin
          freeze   = 1'b1;
          stall_pc = 1'b1;
          stall_id = 1'b1;
        end
        MODE_TAKEN: begin
          flush_ex = 1'b1;
          flush_id = 1'b1;
        end
        MODE_LU: begin
          stall_pc = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        MODE_ADV: begin
          stall_pc = 1'b0;
        end
        default: begin
          stall_pc = 1'b0;
        end
      endcase
    end
  end

  // Shadow pipeline, forwarding selects and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r         <= SHADOW_NONE;
      mem_r        <= SHADOW_NONE;
      fwd_src1     <= RS_DATA;
      fwd_src2     <= RS_DATA;
      lu_stall_cnt <= 32'd0;
      flush_cnt    <= 32'd0;
      freeze_cnt   <= 32'd0;
    end else begin
      case (mode_s)
        MODE_FREEZE: begin
          freeze_cnt <= freeze_cnt + 32'd1;
        end
        MODE_TAKEN: begin
          ex_r      <= SHADOW_NONE;
          mem_r     <= ex_r;
          flush_cnt <= flush_cnt + 32'd1;
        end
        MODE_LU: begin
          ex_r         <= SHADOW_NONE;
          mem_r        <= ex_r;
          fwd_src1     <= RS_DATA;
          fwd_src2     <= RS_DATA;
          lu_stall_cnt <= lu_stall_cnt + 32'd1;
        end
        MODE_ADV: begin
          ex_r     <= id_shadow_s;
          mem_r    <= ex_r;
          fwd_src1 <= fwd1_s;
          fwd_src2 <= fwd2_s;
        end
        default: begin
          ex_r <= ex_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: expectations are queued as each
// cycle's stimulus is driven and checked when the combinational/registered outputs settle.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ex_taken, mem_busy;
  logic [1:0]  fwd_src1, fwd_src2;
  logic        stall_pc, stall_id, flush_ex, flush_id, freeze;
  logic [31:0] lu_stall_cnt, flush_cnt, freeze_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_taken(ex_taken), .mem_busy(mem_busy),
    .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
    .stall_pc(stall_pc), .stall_id(stall_id), .flush_ex(flush_ex),
    .flush_id(flush_id), .freeze(freeze),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  string       cur_tag;
  logic [31:0] m_lu = 32'd0, m_fl = 32'd0, m_fz = 32'd0;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rs1_addr = r1; id_rs1_used = u1;
    id_rs2_addr = r2; id_rs2_used = u2;
    id_rd_addr = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0: return {27'd0, stall_pc, stall_id, flush_ex, flush_id, freeze};
      1: return {30'd0, fwd_src1};
      2: return {30'd0, fwd_src2};
      3: return lu_stall_cnt;
      4: return flush_cnt;
      5: return freeze_cnt;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_item(input exp_t it);
    logic [31:0] obs;
    obs = observe(it.kind);
    n_assert++;
    assert (obs === it.val) else begin
      n_fail++;
      $error("FAIL %s kind=%0d observed=%0h expected=%0h", cur_tag, it.kind, obs, it.val);
    end
  endtask

  // ec = {stall_pc, stall_id, flush_ex, flush_id, freeze}
  task automatic cycle(input string tag, input logic [4:0] ec,
                       input logic [1:0] ef1, input logic [1:0] ef2);
    exp_t it;
    cur_tag = tag;
    if (rst) begin
      m_lu = 32'd0; m_fl = 32'd0; m_fz = 32'd0;
    end else if (ec[0]) begin
      m_fz = m_fz + 32'd1;
    end else if (ec[1]) begin
      m_fl = m_fl + 32'd1;
    end else if (ec[4]) begin
      m_lu = m_lu + 32'd1;
    end
    sb.push_back('{0, {27'd0, ec}});
    sb.push_back('{1, {30'd0, ef1}});
    sb.push_back('{2, {30'd0, ef2}});
    sb.push_back('{3, m_lu});
    sb.push_back('{4, m_fl});
    sb.push_back('{5, m_fz});
    #2;
    it = sb.pop_front();
    check_item(it);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check_item(it);
    end
  endtask

  initial begin
    rst = 1'b1; ex_taken = 1'b0; mem_busy = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    cycle("reset", 5'b00110, 2'd0, 2'd0);
    rst = 1'b0;

    // EX/MEM forwarding, youngest wins
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    cycle("add_x5", 5'b00000, 2'd0, 2'd0);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    cycle("fwd1_ex", 5'b00000, 2'd1, 2'd0);
    set_id(1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
    cycle("fwd2_ex_beats_mem", 5'b00000, 2'd0, 2'd1);
    set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle("fwd2_mem", 5'b00000, 2'd0, 2'd2);
    set_id(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle("invalid_id_no_fwd", 5'b00000, 2'd0, 2'd0);

    // load-use stall then WB forwarding
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    cycle("lw_x7", 5'b00000, 2'd0, 2'd0);
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    cycle("lu_stall", 5'b11100, 2'd0, 2'd0);
    cycle("lu_resume_wb", 5'b00000, 2'd2, 2'd0);

    rst = 1'b1;
    cycle("reset2", 5'b00110, 2'd0, 2'd0);
    rst = 1'b0;

    // taken beats load-use
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    cycle("lw_x10", 5'b00000, 2'd0, 2'd0);
    set_id(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    ex_taken = 1'b1;
    cycle("taken_over_lu", 5'b00110, 2'd0, 2'd0);
    ex_taken = 1'b0;
    cycle("after_taken_mem", 5'b00000, 2'd0, 2'd2);

    // mem_busy freezes a pending load-use for 3 cycles
    set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    cycle("lw_x12", 5'b00000, 2'd1, 2'd0);
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cycle("freeze", 5'b11001, 2'd1, 2'd0);
    mem_busy = 1'b0;
    cycle("lu_after_freeze", 5'b11100, 2'd0, 2'd0);
    cycle("wb_after_freeze", 5'b00000, 2'd2, 2'd0);

    // x0 destination never hazards
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    cycle("lw_x0", 5'b00000, 2'd0, 2'd0);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd15, 1'b1, 1'b0);
    cycle("read_x0", 5'b00000, 2'd0, 2'd0);

    // reset mid-freeze
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1);
    cycle("lw_x14", 5'b00000, 2'd0, 2'd0);
    set_id(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
    mem_busy = 1'b1;
    cycle("freeze2", 5'b11001, 2'd0, 2'd0);
    rst = 1'b1;
    cycle("rst_over_busy", 5'b00110, 2'd0, 2'd0);
    rst = 1'b0; mem_busy = 1'b0;
    cycle("post_rst_clear", 5'b00000, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
